// File: rtl/riscv_alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the ALU/MDU execute unit.
package riscv_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_MUL  = 4'd8;
  localparam logic [3:0] ALU_MULH = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;
  localparam logic [3:0] ALU_DIVU = 4'd11;
  localparam logic [3:0] ALU_NOR  = 4'd12;
  localparam logic [3:0] ALU_REM  = 4'd13;
  localparam logic [3:0] ALU_REMU = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Widest XLEN the magnitude helper supports; callers zero-extend and truncate.
  localparam int MAG_W = 64;

  // Two's-complement magnitude: negate when the sign flag is set, else pass through.
  function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] value,
                                                input logic             negative);
    return negative ? (~value + MAG_W'(1)) : value;
  endfunction

endpackage

// File: rtl/riscv_alu_mdu_divider.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// o_quotient/o_remainder show the values after the current step, so the parent
// can register the final answer on the same edge that o_done is high.
module riscv_iter_divider
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic            r_busy;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_divisor;

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  // Shift in the next dividend bit and try subtracting the divisor.
  assign w_shift     = {r_rem, r_quot[XLEN-1]};
  assign w_diff      = w_shift - {1'b0, r_divisor};
  assign w_fits      = ~w_diff[XLEN];
  assign o_remainder = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign o_quotient  = {r_quot[XLEN-2:0], w_fits};
  assign o_done      = r_busy && (r_count == CW'(1));

  // Load operands on start, then run XLEN restoring steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_count   <= CW'(XLEN);
      r_rem     <= '0;
      r_quot    <= i_dividend;
      r_divisor <= i_divisor;
    end else if (r_busy) begin
      r_rem   <= o_remainder;
      r_quot  <= o_quotient;
      r_count <= r_count - CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_alu_mdu.sv
// Handshaked execute-stage ALU with iterative RV32M multiply/divide.
// Logic ops and divide special cases finish in one cycle; MUL/MULH iterate
// shift-add unless FAST_MUL, DIV/REM iterate in riscv_iter_divider.
module riscv_alu_mdu
  import riscv_alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [3:0]      i_alu_ctl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  localparam int CW = $clog2(XLEN + 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_op;
  logic              r_neg;
  logic [CW-1:0]     r_count;
  logic [2*XLEN-1:0] r_mcand;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_result;
  logic              r_zero;

  logic              w_accept;
  logic              w_is_mul, w_is_div, w_div_signed, w_take_mag;
  logic              w_div_by_zero, w_div_ovf, w_to_mul, w_to_div, w_res_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_single_result;
  logic [2*XLEN-1:0] w_a_sx, w_b_sx, w_fast_prod;
  logic [2*XLEN-1:0] w_mul_sum, w_mul_full;
  logic [XLEN-1:0]   w_mul_result;
  logic              w_mul_last;
  logic              w_div_done;
  logic [XLEN-1:0]   w_div_quot, w_div_rem, w_div_result;

  assign w_accept      = i_in_valid && o_in_ready;
  assign w_is_mul      = (i_alu_ctl == ALU_MUL) || (i_alu_ctl == ALU_MULH);
  assign w_is_div      = (i_alu_ctl == ALU_DIV) || (i_alu_ctl == ALU_DIVU) ||
                         (i_alu_ctl == ALU_REM) || (i_alu_ctl == ALU_REMU);
  assign w_div_signed  = (i_alu_ctl == ALU_DIV) || (i_alu_ctl == ALU_REM);
  assign w_take_mag    = w_is_mul || w_div_signed;
  assign w_div_by_zero = (i_b == '0);
  assign w_div_ovf     = w_div_signed && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
  assign w_to_mul      = w_is_mul && !FAST_MUL;
  assign w_to_div      = w_is_div && !w_div_by_zero && !w_div_ovf;

  // Iterative units work on magnitudes; the sign is reapplied at the end.
  assign w_a_mag   = XLEN'(twos_mag(MAG_W'(i_a), w_take_mag && i_a[XLEN-1]));
  assign w_b_mag   = XLEN'(twos_mag(MAG_W'(i_b), w_take_mag && i_b[XLEN-1]));
  assign w_res_neg = (i_alu_ctl == ALU_REM) ? i_a[XLEN-1]
                                            : (w_take_mag && (i_a[XLEN-1] ^ i_b[XLEN-1]));

  assign w_a_sx      = {{XLEN{i_a[XLEN-1]}}, i_a};
  assign w_b_sx      = {{XLEN{i_b[XLEN-1]}}, i_b};
  assign w_fast_prod = $signed(w_a_sx) * $signed(w_b_sx);

  // Result of every operation that completes in the accept cycle.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_single_result = '0;
    case (i_alu_ctl)
      ALU_AND:  w_single_result = i_a & i_b;
      ALU_OR:   w_single_result = i_a | i_b;
      ALU_ADD:  w_single_result = i_a + i_b;
      ALU_SUB:  w_single_result = i_a - i_b;
      ALU_SLTU: w_single_result = XLEN'(i_a < i_b);
      ALU_SLT:  w_single_result = XLEN'($signed(i_a) < $signed(i_b));
      ALU_NOR:  w_single_result = ~(i_a | i_b);
      ALU_MUL:  w_single_result = w_fast_prod[XLEN-1:0];
      ALU_MULH: w_single_result = w_fast_prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU: begin
        if (w_div_by_zero)  w_single_result = '1;
        else if (w_div_ovf) w_single_result = i_a;
      end
      ALU_REM, ALU_REMU: begin
        if (w_div_by_zero) w_single_result = i_a;
      end
      default: w_single_result = '0;
    endcase
  end

  // One shift-add step; the final step also applies the sign and picks the half.
  assign w_mul_sum    = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_full   = r_neg ? (~w_mul_sum + (2*XLEN)'(1)) : w_mul_sum;
  assign w_mul_result = (r_op == ALU_MULH) ? w_mul_full[2*XLEN-1:XLEN] : w_mul_full[XLEN-1:0];
  assign w_mul_last   = (r_count == CW'(1));

  riscv_iter_divider #(.XLEN(XLEN)) u_divider (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_accept && w_to_div),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quot),
    .o_remainder (w_div_rem)
  );

  assign w_div_result = XLEN'(twos_mag(MAG_W'(((r_op == ALU_REM) || (r_op == ALU_REMU))
                                              ? w_div_rem : w_div_quot), r_neg));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so all flops update together on the edge.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = w_to_mul ? ST_MUL : (w_to_div ? ST_DIV : ST_DONE);
      ST_MUL:  if (w_mul_last) w_next_state = ST_DONE;
      ST_DIV:  if (w_div_done) w_next_state = ST_DONE;
      ST_DONE: if (i_out_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_in_ready  = (r_state == ST_IDLE);
    o_out_valid = (r_state == ST_DONE);
  end

  assign o_result = r_result;
  assign o_zero   = r_zero;

  // Operand capture, multiply iteration and result/zero registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_count  <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_op     <= i_alu_ctl;
      r_neg    <= w_res_neg;
      r_count  <= CW'(XLEN);
      r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
      r_prod   <= '0;
      r_mplier <= w_b_mag;
      if (!w_to_mul && !w_to_div) begin
        r_result <= w_single_result;
        r_zero   <= (w_single_result == '0);
      end
    end else if (r_state == ST_MUL) begin
      r_prod   <= w_mul_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - CW'(1);
      if (w_mul_last) begin
        r_result <= w_mul_result;
        r_zero   <= (w_mul_result == '0);
      end
    end else if ((r_state == ST_DIV) && w_div_done) begin
      r_result <= w_div_result;
      r_zero   <= (w_div_result == '0);
    end
  end

endmodule

// File: tb/tb_riscv_alu_mdu.sv
// Directed-vector bench for riscv_alu_mdu: iterative (dut0) and FAST_MUL (dut1) builds.
module tb_riscv_alu_mdu;
  import riscv_alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      alu_ctl = '0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;

  logic            in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic            in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic            in_ready0, out_valid0, zero0;
  logic            in_ready1, out_valid1, zero1;
  logic [XLEN-1:0] result0, result1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_alu_mdu #(.XLEN(XLEN), .FAST_MUL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid0), .o_in_ready(in_ready0),
    .i_alu_ctl(alu_ctl), .i_a(a), .i_b(b),
    .o_out_valid(out_valid0), .i_out_ready(out_ready0),
    .o_result(result0), .o_zero(zero0)
  );

  riscv_alu_mdu #(.XLEN(XLEN), .FAST_MUL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid1), .o_in_ready(in_ready1),
    .i_alu_ctl(alu_ctl), .i_a(a), .i_b(b),
    .o_out_valid(out_valid1), .i_out_ready(out_ready1),
    .o_result(result1), .o_zero(zero1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure accept-to-out_valid latency, check, then drain.
  task automatic do_op(input bit d, input string tag, input logic [3:0] op,
                       input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb,
                       input logic [XLEN-1:0] exp_res, input logic exp_z,
                       input int exp_lat);
    int lat;
    @(negedge clk);
    alu_ctl = op; a = va; b = vb;
    if (d) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    check({tag, "_in_ready"}, d ? in_ready1 : in_ready0, 1);
    @(negedge clk);
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    lat = 1;
    while (!(d ? out_valid1 : out_valid0) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, d ? result1 : result0, exp_res);
    check({tag, "_zero"}, d ? zero1 : zero0, exp_z);
    if (d) out_ready1 = 1'b1; else out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0; out_ready1 = 1'b0;
  endtask

  initial begin
    bit seen;

    // Reset held with a pending request.
    in_valid0 = 1'b1; alu_ctl = ALU_ADD; a = 32'd1; b = 32'd2;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid0, 0);
    check("rst_result", result0, 0);
    check("rst_zero", zero0, 0);
    rst_n = 1'b1;
    #1;
    check("rst_rel_in_ready", in_ready0, 1);
    check("rst_rel_out_valid", out_valid0, 0);
    check("rst_rel_result", result0, 0);
    in_valid0 = 1'b0;

    // Reset in the middle of a divide aborts it.
    @(negedge clk);
    alu_ctl = ALU_DIV; a = 32'd100; b = 32'd7; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    check("abort_busy", in_ready0, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid0) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_idle", in_ready0, 1);

    // Single-cycle ops.
    do_op(0, "sub_eq",  ALU_SUB,  32'd5,        32'd5,        32'd0,        1'b1, 1);
    do_op(0, "add_wrap",ALU_ADD,  32'hFFFF_FFFF,32'd1,        32'd0,        1'b1, 1);
    do_op(0, "slt",     ALU_SLT,  32'hFFFF_FFFF,32'd1,        32'd1,        1'b0, 1);
    do_op(0, "sltu",    ALU_SLTU, 32'hFFFF_FFFF,32'd1,        32'd0,        1'b1, 1);
    do_op(0, "and",     ALU_AND,  32'h0000_F0F0,32'h0000_FF00,32'h0000_F000,1'b0, 1);
    do_op(0, "nor",     ALU_NOR,  32'd0,        32'd0,        32'hFFFF_FFFF,1'b0, 1);
    do_op(0, "undef5",  4'd5,     32'd3,        32'd4,        32'd0,        1'b1, 1);

    // Iterative multiply.
    do_op(0, "mul_ovf", ALU_MUL,  32'h0001_0000,32'h0001_0000,32'd0,        1'b1, 33);
    do_op(0, "mulh_neg",ALU_MULH, 32'hFFFF_FFFE,32'd3,        32'hFFFF_FFFF,1'b0, 33);
    do_op(0, "mul_neg", ALU_MUL,  32'hFFFF_FFFE,32'd3,        32'hFFFF_FFFA,1'b0, 33);

    // Fast multiply build.
    do_op(1, "fmul_ovf", ALU_MUL, 32'h0001_0000,32'h0001_0000,32'd0,        1'b1, 1);
    do_op(1, "fmulh_neg",ALU_MULH,32'hFFFF_FFFE,32'd3,        32'hFFFF_FFFF,1'b0, 1);

    // Iterative divide/remainder.
    do_op(0, "div_neg", ALU_DIV,  32'hFFFF_FFF9,32'd2,        32'hFFFF_FFFD,1'b0, 33);
    do_op(0, "rem_neg", ALU_REM,  32'hFFFF_FFF9,32'd2,        32'hFFFF_FFFF,1'b0, 33);
    do_op(0, "divu",    ALU_DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 33);
    do_op(0, "remu",    ALU_REMU, 32'd100,      32'd7,        32'd2,        1'b0, 33);

    // Divide special cases.
    do_op(0, "div_z",   ALU_DIV,  32'd5,        32'd0,        32'hFFFF_FFFF,1'b0, 1);
    do_op(0, "rem_z",   ALU_REM,  32'd9,        32'd0,        32'd9,        1'b0, 1);
    do_op(0, "div_ovf", ALU_DIV,  32'h8000_0000,32'hFFFF_FFFF,32'h8000_0000,1'b0, 1);
    do_op(0, "rem_ovf", ALU_REM,  32'h8000_0000,32'hFFFF_FFFF,32'd0,        1'b1, 1);

    // Back-pressure: result held, new requests ignored until transfer.
    @(negedge clk);
    alu_ctl = ALU_ADD; a = 32'd3; b = 32'd4; in_valid0 = 1'b1;
    @(negedge clk);
    check("bp_valid", out_valid0, 1);
    alu_ctl = ALU_OR; a = 32'h0000_00F0; b = 32'h0000_000F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid0, 1);
      check("bp_hold_result", result0, 32'd7);
      check("bp_hold_zero", zero0, 0);
      check("bp_hold_in_ready", in_ready0, 0);
    end
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    check("bp_xfer_valid", out_valid0, 0);
    check("bp_xfer_idle", in_ready0, 1);
    @(negedge clk);
    in_valid0 = 1'b0;
    check("bp_next_valid", out_valid0, 1);
    check("bp_next_result", result0, 32'h0000_00FF);
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_alu_mdu.md
Name: riscv_alu_mdu

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU.
- Keeps the existing 4-bit ALUctl encodings (AND/OR/ADD/SUB/SLT/NOR) and adds SLTU and the RV32M multiply/divide group, executed iteratively.
- Zero flag is defined for every operation and registered with the result.
- Sits in the execute stage; the control unit stalls while in_ready or out_valid is low.

Parameters:
- XLEN, 32, operand/result width (≥8, even).
- FAST_MUL, 0, 1 = MUL/MULH complete in one cycle like the logic ops; 0 = iterative shift-add over XLEN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- alu_ctl  input  4  operation code (see Behaviour)
- a  input  XLEN  operand A (rs1)
- b  input  XLEN  operand B (rs2/imm)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  operation result
- zero  output  1  result == 0, valid with out_valid

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SLTU, 6 SUB, 7 SLT (signed), 12 NOR.
  - 8 MUL (low XLEN), 9 MULH (signed×signed, high XLEN).
  - 10 DIV, 11 DIVU, 13 REM, 14 REMU.
  - Any other code: result 0, zero 1, single-cycle.
- Reset (async, rst_n low) sets:
  - state IDLE, in_ready 1.
  - out_valid 0, result 0, zero 0.
  - Iteration counter and partial registers cleared.
  - Reset mid-operation aborts it; no result is produced.
- Handshake:
  - A request is accepted on a rising edge with in_valid && in_ready.
  - Operands and opcode are captured at acceptance; later input changes are ignored.
  - in_ready = (state == IDLE).
  - The result is held stable while out_valid && !out_ready.
  - Transfer occurs on an edge with out_valid && out_ready, then state returns to IDLE.
  - No new request is accepted in the transfer cycle: minimum one-cycle bubble between results.
- States:
  - IDLE: on accept, single-cycle op (or MUL/MULH with FAST_MUL=1) → DONE; multiply → MUL; divide/remainder → DIV.
  - MUL: one shift-add step per cycle on operand magnitudes; after XLEN steps → DONE.
  - DIV: restoring radix-2 step per cycle on magnitudes; after XLEN steps → DONE.
  - DONE: out_valid 1; on out_ready → IDLE.
  - Result/zero registers are written on the edge entering DONE.
- Latency, from accept edge to out_valid high:
  - 1 cycle for single-cycle ops.
  - XLEN+1 cycles for iterative ops.
  - Counter is ceil(log2(XLEN+1)) bits, counts XLEN down to 0.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU return 1 or 0 zero-extended.
  - MUL product is 2·XLEN bits internally.
  - MULH negates the full product if operand signs differ, then takes the upper half.
  - Signed DIV/REM: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases (resolved in IDLE, still reported via DONE with latency 1):
  - Divide by zero: DIV/DIVU result all-ones; REM/REMU result = a.
  - Signed overflow (a = −2^(XLEN−1), b = −1): DIV result = a; REM result 0.
- zero = (result == 0) for every opcode, including SUB, MUL and DIV.

Decomposition:
- Shared package riscv_alu_pkg holds:
  - alu_ctl localparams (ALU_AND=4'd0 … ALU_REMU=4'd14).
  - State encodings IDLE/MUL/DIV/DONE.
  - A helper function for two's-complement magnitude.
- One natural sub-module: riscv_iter_divider, which owns the DIV state's remainder/quotient registers and step logic with start/done.
- Multiply and logic ops stay in the top level.

Test Plan:
- Reset held low with in_valid=1 → in_ready=1 after release, out_valid=0, result=0; assert reset during a DIV at cycle 10 → no out_valid, IDLE on release.
- SUB a=5 b=5 → out_valid after 1 cycle, result=0, zero=1; ADD 0xFFFFFFFF+1 → result 0, zero=1; SLT −1,1 → 1; SLTU −1,1 → 0.
- MUL 0x0001_0000×0x0001_0000 → result 0, zero=1, out_valid exactly 33 cycles after accept; MULH −2×3 → 0xFFFFFFFF; repeat with FAST_MUL=1 → 1-cycle latency.
- DIV −7/2 → −3; REM −7/2 → −1; DIVU 100/7 → 14; REMU 100/7 → 2; each out_valid at accept+33.
- DIV x/0 → 0xFFFFFFFF; REM 9/0 → 9; DIV 0x80000000/−1 → 0x80000000; REM same operands → 0 with zero=1; all at 1-cycle latency.
- Back-pressure: out_ready low 5 cycles → result, zero and out_valid stable, in_ready=0, new in_valid ignored; out_ready high → IDLE next edge and next request accepted.
